fetch_controller: RTL and testbench

//   Instruction-fetch sequencer for the 5-stage CPU. Owns the program counter and drives
//   the instruction memory address. Captures the instruction that the memory returns

---
 rtl/fetch_controller_if.sv | 52 +++++
 rtl/fetch_controller.sv | 99 +++++++++
 tb/tb_fetch_controller.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_controller_if.sv
// Bundle of fetch-side signals between the fetch controller, instruction memory and pipeline.
// FETCH_PERF_EN adds the fetch_count performance counter to the bundle.
interface fetch_controller_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic               start;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               stall;
  logic               flush;
  logic [ADDR_W-1:0]  branch_target;
  logic [INSTR_W-1:0] ifid_instr;
  logic [ADDR_W-1:0]  ifid_pc;
  logic               ifid_valid;
  logic               halted;
`ifdef FETCH_PERF_EN
  logic [15:0]        fetch_count;
`endif

  modport master (
    input  start,
    input  imem_data,
    input  stall,
    input  flush,
    input  branch_target,
`ifdef FETCH_PERF_EN
    output fetch_count,
`endif
    output imem_addr,
    output ifid_instr,
    output ifid_pc,
    output ifid_valid,
    output halted
  );

  modport slave (
    output start,
    output imem_data,
    output stall,
    output flush,
    output branch_target,
`ifdef FETCH_PERF_EN
    input  fetch_count,
`endif
    input  imem_addr,
    input  ifid_instr,
    input  ifid_pc,
    input  ifid_valid,
    input  halted
  );
endinterface

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, loads IF/ID, handles stall/flush/halt.
// Define FETCH_PERF_EN to add the saturating fetch_count performance counter.
module fetch_controller #(
  parameter int ADDR_W   = 16,
  parameter int INSTR_W  = 16,
  parameter int PC_STEP  = 2,
  parameter int PC_RESET = 0,
  parameter int PC_MAX   = 50
) (
  input  logic              clock,
  input  logic              reset,
  fetch_controller_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALT
  } fetchState_t;

  fetchState_t        state;
  logic [ADDR_W-1:0]  programCounter;
  logic [INSTR_W-1:0] ifidInstr;
  logic [ADDR_W-1:0]  ifidPc;
  logic               ifidValid;
  logic               haltedReg;
  logic [ADDR_W-1:0]  redirectPc;
  logic               haltCondition;

  // Instructions live at even addresses, so a branch target is forced even.
  assign redirectPc    = bus.branch_target & ~ADDR_W'(1);
  assign haltCondition = (bus.imem_data == '0) || (programCounter > ADDR_W'(PC_MAX));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      programCounter <= ADDR_W'(PC_RESET);
      ifidInstr      <= '0;
      ifidPc         <= '0;
      ifidValid      <= 1'b0;
      haltedReg      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= FETCH;
          end
        end
        FETCH: begin
          if (bus.flush) begin
            programCounter <= redirectPc;
            ifidValid      <= 1'b0;
            ifidInstr      <= '0;
          end else if (bus.stall) begin
            programCounter <= programCounter;
          end else if (haltCondition) begin
            state     <= HALT;
            haltedReg <= 1'b1;
            ifidValid <= 1'b0;
          end else begin
            ifidInstr      <= bus.imem_data;
            ifidPc         <= programCounter;
            ifidValid      <= 1'b1;
            programCounter <= programCounter + ADDR_W'(PC_STEP);
          end
        end
        HALT: begin
          ifidValid <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] fetchCount;

  // Counts exactly the edges that load a real instruction into IF/ID.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetchCount <= '0;
    end else if ((state == FETCH) && !bus.flush && !bus.stall && !haltCondition
                 && (fetchCount != 16'hFFFF)) begin
      fetchCount <= fetchCount + 16'd1;
    end
  end

  assign bus.fetch_count = fetchCount;
`endif

  assign bus.imem_addr  = programCounter;
  assign bus.ifid_instr = ifidInstr;
  assign bus.ifid_pc    = ifidPc;
  assign bus.ifid_valid = ifidValid;
  assign bus.halted     = haltedReg;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: directed scenarios then randomized episodes,
// all compared every cycle against a behavioural fetch model.
module tb_fetch_controller;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  fetch_controller_if #(.ADDR_W(16), .INSTR_W(16)) bus ();

  fetch_controller #(
    .ADDR_W(16), .INSTR_W(16), .PC_STEP(2), .PC_RESET(0), .PC_MAX(50)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  logic [15:0] mem [256];
  assign bus.imem_data = (bus.imem_addr < 16'd256) ? mem[bus.imem_addr[7:0]] : 16'h0000;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  bit          mStarted;
  bit          mHalted;
  logic [15:0] mPc;
  logic [15:0] mInstr;
  logic [15:0] mIfPc;
  bit          mValid;
  int          mCount;

  function automatic logic [15:0] memAt(logic [15:0] a);
    return (a < 16'd256) ? mem[a[7:0]] : 16'h0000;
  endfunction

  task automatic checkEq(string tag, logic [31:0] obs, logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mStarted = 0;
    mHalted  = 0;
    mPc      = 16'h0000;
    mInstr   = 16'h0000;
    mIfPc    = 16'h0000;
    mValid   = 0;
    mCount   = 0;
  endtask

  // One rising edge of the fetch sequencer, written from the behavioural rules.
  task automatic modelStep();
    logic [15:0] word;
    word = memAt(mPc);
    if (mHalted) begin
      mValid = 0;
    end else if (!mStarted) begin
      if (bus.start) mStarted = 1;
    end else if (bus.flush) begin
      mPc    = bus.branch_target & 16'hFFFE;
      mValid = 0;
      mInstr = 16'h0000;
    end else if (bus.stall) begin
      mPc = mPc;
    end else if (word == 16'h0000 || mPc > 16'd50) begin
      mHalted  = 1;
      mStarted = 0;
      mValid   = 0;
    end else begin
      mInstr = word;
      mIfPc  = mPc;
      mValid = 1;
      mPc    = mPc + 16'd2;
      if (mCount < 65535) mCount++;
    end
  endtask

  task automatic checkOutput();
    checkEq("imem_addr", 32'(bus.imem_addr), 32'(mPc));
    checkEq("ifid_instr", 32'(bus.ifid_instr), 32'(mInstr));
    checkEq("ifid_pc", 32'(bus.ifid_pc), 32'(mIfPc));
    checkEq("ifid_valid", 32'(bus.ifid_valid), 32'(mValid));
    checkEq("halted", 32'(bus.halted), 32'(mHalted));
`ifdef FETCH_PERF_EN
    checkEq("fetch_count", 32'(bus.fetch_count), 32'(mCount));
`endif
  endtask

  task automatic applyStimulus(bit st, bit sl, bit fl, logic [15:0] tgt);
    bus.start         = st;
    bus.stall         = sl;
    bus.flush         = fl;
    bus.branch_target = tgt;
  endtask

  task automatic cycle();
    @(posedge clock);
    modelStep();
    @(negedge clock);
    checkOutput();
  endtask

  // Reset lands between edges so the zeroing can only come from the async path.
  task automatic doReset(int cycles);
    applyStimulus(0, 0, 0, 16'h0000);
    #2 reset = 1'b0;
    modelReset();
    #1;
    checkEq("rst_addr", 32'(bus.imem_addr), 32'h0);
    checkEq("rst_halted", 32'(bus.halted), 32'h0);
    checkOutput();
    repeat (cycles) @(negedge clock);
    reset = 1'b1;
    #1 checkOutput();
  endtask

  task automatic loadProgram(bit withZeros);
    for (int a = 0; a < 256; a++) begin
      if (withZeros && $urandom_range(0, 19) == 0) mem[a] = 16'h0000;
      else mem[a] = 16'($urandom_range(1, 65535));
    end
    mem[50] = 16'h0000;
  endtask

  initial begin
    applyStimulus(0, 0, 0, 16'h0000);
    modelReset();
    loadProgram(0);
    mem[0] = 16'h012f;
    mem[2] = 16'h012e;
    #1 checkOutput();
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // Start-up and first two fetches
    applyStimulus(1, 0, 0, 16'h0000);
    cycle();
    checkEq("t1_valid_first", 32'(bus.ifid_valid), 32'h0);
    applyStimulus(0, 0, 0, 16'h0000);
    cycle();
    checkEq("t1_pc0", 32'(bus.ifid_pc), 32'h0);
    checkEq("t1_instr0", 32'(bus.ifid_instr), 32'h012f);
    cycle();
    checkEq("t1_pc2", 32'(bus.ifid_pc), 32'h2);
    checkEq("t1_instr2", 32'(bus.ifid_instr), 32'h012e);
    checkEq("t1_addr4", 32'(bus.imem_addr), 32'h4);

    // Stall holds PC and IF/ID
    applyStimulus(0, 1, 0, 16'h0000);
    repeat (3) cycle();
    checkEq("t2_addr_hold", 32'(bus.imem_addr), 32'h4);
    checkEq("t2_pc_hold", 32'(bus.ifid_pc), 32'h2);
    applyStimulus(0, 0, 0, 16'h0000);
    cycle();
    checkEq("t2_pc_after", 32'(bus.ifid_pc), 32'h4);

    // Flush with an odd target
    for (int i = 0; i < 40 && mPc != 16'h0018; i++) cycle();
    checkEq("t3_at_18", 32'(bus.imem_addr), 32'h18);
    applyStimulus(0, 0, 1, 16'h0021);
    cycle();
    checkEq("t3_valid", 32'(bus.ifid_valid), 32'h0);
    checkEq("t3_addr", 32'(bus.imem_addr), 32'h20);
    applyStimulus(0, 0, 0, 16'h0000);
    cycle();
    checkEq("t3_ifid_pc", 32'(bus.ifid_pc), 32'h20);

    // Flush beats stall
    applyStimulus(0, 1, 1, 16'h0010);
    cycle();
    checkEq("t4_addr", 32'(bus.imem_addr), 32'h10);
    checkEq("t4_valid", 32'(bus.ifid_valid), 32'h0);
    applyStimulus(0, 0, 0, 16'h0000);
    cycle();

    // Full program run to the zero word at 50
    doReset(2);
    applyStimulus(1, 0, 0, 16'h0000);
    for (int i = 0; i < 80 && !mHalted; i++) cycle();
    checkEq("t5_halted", 32'(bus.halted), 32'h1);
    checkEq("t5_valid", 32'(bus.ifid_valid), 32'h0);
    checkEq("t5_addr", 32'(bus.imem_addr), 32'd50);
`ifdef FETCH_PERF_EN
    checkEq("t5_count", 32'(bus.fetch_count), 32'd25);
`endif
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom_range(0, 40)));
      cycle();
    end
    checkEq("t5_halt_hold", 32'(bus.halted), 32'h1);
    checkEq("t5_addr_hold", 32'(bus.imem_addr), 32'd50);

    // Asynchronous reset mid-run
    doReset(2);
    applyStimulus(1, 0, 0, 16'h0000);
    for (int i = 0; i < 20 && mPc != 16'h000C; i++) cycle();
    checkEq("t6_at_0c", 32'(bus.imem_addr), 32'hC);
    doReset(2);
    repeat (3) cycle();

    // Randomized episodes
    for (int ep = 0; ep < 12; ep++) begin
      loadProgram(1);
      doReset(1 + int'($urandom_range(0, 1)));
      for (int i = 0; i < 60; i++) begin
        applyStimulus(1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                      ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 60)));
        cycle();
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
